// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-master Wishbone arbiter: the FSM state
//   encoding, the data bus width and the master index type used by the
//   round-robin picker.
package mem_arbiter_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    typedef logic mst_idx_t;
    localparam mst_idx_t MST0 = 1'b0;
    localparam mst_idx_t MST1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// arb_rr2
//   Two-way round-robin pick with a last-owner register.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_req0, i_req1  requests from master 0 / master 1
//     i_upd           a master is entering ownership this cycle
//     i_upd_idx       index of the master entering ownership
//     o_pick          index of the master to grant (valid when any request)
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_req0,
    input  logic     i_req1,
    input  logic     i_upd,
    input  mst_idx_t i_upd_idx,
    output mst_idx_t o_pick
);

    mst_idx_t r_last;

    // Reset to master 1 so master 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= MST1;
        end else if (i_upd) begin
            r_last <= i_upd_idx;
        end
    end

    // On a tie the master that did not own last goes next.
    assign o_pick = (i_req0 && i_req1) ? ~r_last : (i_req1 ? MST1 : MST0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates two Wishbone masters (m0 = instruction fill, m1 = data) onto
//   one shared slave. Grant is parked for PARK idle cycles after the owner
//   drops cyc; a stalled strobe is terminated with err after TIMEOUT cycles.
//   Ports:
//     clk_i, rst_n_i                      clock, asynchronous active-low reset
//     mN_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i  master N request
//     mN_dat_o/ack_o/err_o                 master N response
//     s_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o shared slave request
//     s_dat_i/ack_i/err_i                  shared slave response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int PARK    = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [31:0]      m0_adr_i,
    input  logic [1:0]       m0_sel_i,
    input  logic [BUS_W-1:0] m0_dat_i,
    output logic [BUS_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [31:0]      m1_adr_i,
    input  logic [1:0]       m1_sel_i,
    input  logic [BUS_W-1:0] m1_dat_i,
    output logic [BUS_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [31:0]      s_adr_o,
    output logic [1:0]       s_sel_o,
    output logic [BUS_W-1:0] s_dat_o,
    input  logic [BUS_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i
);

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [3:0]  PARK_L     = 4'(PARK);

    state_t      r_state;
    state_t      w_next;
    logic        r_parked;
    logic [3:0]  r_park_cnt;
    logic [15:0] r_stall_cnt;

    logic        w_own0, w_own1;
    logic        w_own_cyc, w_own_stb, w_other_req;
    logic        w_timeout, w_expire, w_enter;
    logic        w_ack, w_err;
    mst_idx_t    w_pick;

    assign w_own0      = (r_state == ST_OWN0);
    assign w_own1      = (r_state == ST_OWN1);
    assign w_own_cyc   = (w_own0 && m0_cyc_i) || (w_own1 && m1_cyc_i);
    assign w_own_stb   = (w_own0 && m0_cyc_i && m0_stb_i) || (w_own1 && m1_cyc_i && m1_stb_i);
    assign w_other_req = w_own0 ? m1_cyc_i : m0_cyc_i;

    // Timeout fires on the TIMEOUT-th stalled cycle itself (count holds the
    // number of stalled cycles already completed).
    assign w_timeout = w_own_stb && (r_stall_cnt == TIMEOUT_M1);

    // Terminations only reach the owner while it holds cyc; ack beats err.
    assign w_ack = w_own_cyc && s_ack_i && !w_timeout;
    assign w_err = w_timeout || (w_own_cyc && s_err_i && !s_ack_i);

    arb_rr2 u_rr2 (
        .i_clk     (clk_i),
        .i_rst_n   (rst_n_i),
        .i_req0    (m0_cyc_i),
        .i_req1    (m1_cyc_i),
        .i_upd     (w_enter),
        .i_upd_idx (w_next == ST_OWN1),
        .o_pick    (w_pick)
    );

    always_comb begin
        w_next   = r_state;
        w_expire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    w_next = (w_pick == MST1) ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_own_cyc) begin
                    // First idle edge loads the park count; PARK=0 releases at once.
                    w_expire = r_parked ? (r_park_cnt <= 4'd1) : (PARK == 0);
                    if (w_expire) begin
                        w_next = w_other_req ? (w_own0 ? ST_OWN1 : ST_OWN0) : ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_enter = (w_next != r_state) && (w_next != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_parked    <= 1'b0;
            r_park_cnt  <= 4'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_next;

            if ((w_next != r_state) || w_own_cyc) begin
                r_parked   <= 1'b0;
                r_park_cnt <= 4'd0;
            end else if (w_own0 || w_own1) begin
                if (!r_parked) begin
                    r_parked   <= 1'b1;
                    r_park_cnt <= PARK_L;
                end else begin
                    r_park_cnt <= r_park_cnt - 4'd1;
                end
            end

            if ((w_next != r_state) || w_timeout || s_ack_i || s_err_i) begin
                r_stall_cnt <= 16'd0;
            end else if (w_own_stb) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        s_cyc_o = w_own_cyc;
        s_stb_o = w_own_stb && !w_timeout;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        if (w_own0) begin
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
        end else if (w_own1) begin
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = w_own0 && w_ack;
    assign m0_err_o = w_own0 && w_err;
    assign m1_ack_o = w_own1 && w_ack;
    assign m1_err_o = w_own1 && w_err;

    // Read data is broadcast, but forced to zero while reset is held.
    assign m0_dat_o = rst_n_i ? s_dat_i : '0;
    assign m1_dat_o = rst_n_i ? s_dat_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr;
    logic [1:0]  m0_sel;
    logic [15:0] m0_dw, m0_dr;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr;
    logic [1:0]  m1_sel;
    logic [15:0] m1_dw, m1_dr;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr;
    logic [1:0]  s_sel;
    logic [15:0] s_dw, s_dr;
    logic        s_ack, s_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] A0 = 32'h1000_0010;
    localparam logic [31:0] A1 = 32'h2000_0020;

    mem_arbiter #(.TIMEOUT(4), .PARK(1)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_sel_i (m0_sel),
        .m0_dat_i (m0_dw),
        .m0_dat_o (m0_dr),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_sel_i (m1_sel),
        .m1_dat_i (m1_dw),
        .m1_dat_o (m1_dr),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_sel_o  (s_sel),
        .s_dat_o  (s_dw),
        .s_dat_i  (s_dr),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic m0_set(input logic c);
        m0_cyc = c;
        m0_stb = c;
    endtask

    task automatic m1_set(input logic c);
        m1_cyc = c;
        m1_stb = c;
    endtask

    initial begin
        int  acks;
        logic m1_early;
        int  g0, g1, gd;

        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 1'b1; m0_adr = A0; m0_sel = 2'b11; m0_dw = 16'hA5A5;
        m1_cyc = 0; m1_stb = 0; m1_we = 1'b0; m1_adr = A1; m1_sel = 2'b01; m1_dw = 16'h5A5A;
        s_dr = 16'hBEEF; s_ack = 1'b1; s_err = 1'b1;

        // Reset state: everything zero while reset held.
        #12;
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_m0_dat", m0_dr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_err", m1_err, 0);
        s_ack = 0; s_err = 0;
        rst_n = 1'b1;

        // Tie after reset: master 0 wins, then master 1 follows after park.
        cyc();
        m0_set(1); m1_set(1);
        #1;
        chk("idle_s_cyc", s_cyc, 0);
        chk("idle_s_adr", s_adr, 0);
        cyc();
        chk("tie_s_cyc", s_cyc, 1);
        chk("tie_s_adr", s_adr, A0);
        chk("tie_s_we", s_we, 1);
        chk("tie_s_dat", s_dw, 16'hA5A5);
        s_ack = 1; s_dr = 16'h1234;
        #1;
        chk("tie_m0_ack", m0_ack, 1);
        chk("tie_m1_ack", m1_ack, 0);
        chk("tie_m1_dat", m1_dr, 16'h1234);
        cyc();
        m0_set(0); s_ack = 0;
        cyc();
        s_ack = 1;
        #1;
        chk("park_s_cyc", s_cyc, 0);
        chk("park_m0_ack", m0_ack, 0);
        chk("park_m1_ack", m1_ack, 0);
        s_ack = 0;
        cyc();
        chk("sw_s_cyc", s_cyc, 1);
        chk("sw_s_adr", s_adr, A1);
        chk("sw_s_we", s_we, 0);
        s_ack = 1;
        #1;
        chk("sw_m1_ack", m1_ack, 1);
        chk("sw_m0_ack", m0_ack, 0);
        cyc();
        m1_set(0); s_ack = 0;
        cyc();
        cyc();
        s_ack = 1;
        #1;
        chk("idle2_s_cyc", s_cyc, 0);
        chk("idle2_m1_ack", m1_ack, 0);
        s_ack = 0;

        // Park keeps master 0 through 16 beats with 1-cycle gaps.
        m0_set(1); m1_set(1);
        cyc();
        acks = 0; m1_early = 0;
        for (int i = 0; i < 16; i++) begin
            s_ack = 1;
            #1;
            if (m0_ack === 1'b1) acks++;
            if (s_cyc === 1'b1 && s_adr === A1) m1_early = 1;
            cyc();
            m0_set(0); s_ack = 0;
            #1;
            if (s_cyc === 1'b1 && s_adr === A1) m1_early = 1;
            cyc();
            if (i != 15) m0_set(1);
        end
        chk("park_m0_acks", acks, 16);
        chk("park_m1_early", m1_early, 0);
        cyc();
        chk("park_m1_grant_cyc", s_cyc, 1);
        chk("park_m1_grant_adr", s_adr, A1);
        s_ack = 1;
        cyc();
        m1_set(0); s_ack = 0;
        cyc();
        cyc();

        // Timeout: m1 alone, slave never answers, TIMEOUT=4.
        m1_set(1);
        cyc();
        chk("to_c1_err", m1_err, 0);
        chk("to_c1_stb", s_stb, 1);
        cyc();
        chk("to_c2_err", m1_err, 0);
        cyc();
        chk("to_c3_err", m1_err, 0);
        cyc();
        chk("to_c4_err", m1_err, 1);
        chk("to_c4_m0_err", m0_err, 0);
        chk("to_c4_stb", s_stb, 0);
        chk("to_c4_cyc", s_cyc, 1);
        cyc();
        chk("to_c5_err", m1_err, 0);
        chk("to_c5_stb", s_stb, 1);
        m1_set(0);
        cyc();
        cyc();
        cyc();

        // Ack and err together: ack wins.
        m0_set(1);
        cyc();
        s_ack = 1; s_err = 1;
        #1;
        chk("ae_m0_ack", m0_ack, 1);
        chk("ae_m0_err", m0_err, 0);
        s_ack = 0;
        #1;
        chk("e_m0_err", m0_err, 1);
        chk("e_m1_err", m1_err, 0);
        cyc();
        s_err = 0;

        // Asynchronous reset mid-beat.
        #1;
        chk("ar_pre_cyc", s_cyc, 1);
        #1;
        rst_n = 0;
        #1;
        chk("ar_s_cyc", s_cyc, 0);
        s_ack = 1;
        #1;
        chk("ar_m0_ack", m0_ack, 0);
        rst_n = 1;
        #1;
        chk("ar_post_cyc", s_cyc, 0);
        chk("ar_post_ack", m0_ack, 0);
        m0_set(0); s_ack = 0;
        cyc();

        // Fairness over 100 contended requests.
        g0 = 0; g1 = 0;
        for (int i = 0; i < 100; i++) begin
            m0_set(1); m1_set(1);
            cyc();
            if (s_cyc === 1'b1 && s_adr === A0) g0++;
            else if (s_cyc === 1'b1 && s_adr === A1) g1++;
            s_ack = 1;
            cyc();
            m0_set(0); m1_set(0); s_ack = 0;
            cyc();
            cyc();
        end
        gd = (g0 > g1) ? g0 - g1 : g1 - g0;
        chk("fair_g0", g0, 50);
        chk("fair_g1", g1, 50);
        chk("fair_diff_le1", (gd <= 1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: slave-stall cycles before a forced error; legal range 1..65535.
REQ-002 Parameter PARK, default 1: idle cycles an owner keeps the grant after dropping cyc; legal range 0..15.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (instruction cache fill port) Wishbone controls.
REQ-006 m0_adr_i  in  32  master 0 byte address.
REQ-007 m0_sel_i  in  2  master 0 byte lane selects.
REQ-008 m0_dat_i  in  16  master 0 write data.
REQ-009 m0_dat_o  out  16  master 0 read data.
REQ-010 m0_ack_o, m0_err_o  out  1 each  master 0 termination.
REQ-011 m1_* (data port)  same names, directions and widths as REQ-005..REQ-010.
REQ-012 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared slave controls.
REQ-013 s_adr_o  out  32  slave address.
REQ-014 s_sel_o  out  2  slave selects.
REQ-015 s_dat_o  out  16  slave write data.
REQ-016 s_dat_i  in  16  slave read data.
REQ-017 s_ack_i, s_err_i  in  1 each  slave termination.

Function
REQ-018 Registered state machine with states IDLE, OWN0 and OWN1, plus a PARK counter and a stall counter.
REQ-019 IDLE: m0_cyc_i only -> OWN0; m1_cyc_i only -> OWN1; both -> the master not recorded as last owner; neither -> stay in IDLE.
REQ-020 Grant latency is exactly one cycle: a request seen in IDLE at edge N drives s_cyc_o from edge N.
REQ-021 In OWNx, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o combinationally follow master x; in IDLE, s_cyc_o and s_stb_o are 0 and the other slave outputs are 0.
REQ-022 s_ack_i and s_err_i route only to the owner; the non-owner's ack_o and err_o are 0; both masters' dat_o equal s_dat_i.
REQ-023 Owner drops cyc: the PARK counter loads PARK; if the owner reasserts cyc while the count is nonzero, it keeps the grant with no arbitration gap.
REQ-024 PARK expires (or PARK=0) with owner cyc low: other master requesting -> go directly to its OWN state; otherwise -> IDLE.
REQ-025 During the park window, s_cyc_o and s_stb_o are 0.
REQ-026 The last-owner flag updates on every entry to OWN0/OWN1; after reset it selects master 1, so master 0 wins the first tie.
REQ-027 The stall counter increments each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0, and clears on ack, on err or on a grant change.
REQ-028 When the stall count reaches TIMEOUT, the owner's err_o pulses for one cycle, s_stb_o is masked that cycle and the counter clears.
REQ-029 s_ack_i and s_err_i both high: ack takes priority and err is dropped.
REQ-030 Terminations arriving in IDLE or during park are discarded.

Reset
REQ-031 While rst_n_i=0, the block holds state IDLE, zero counters, last owner = master 1, and all outputs 0.
REQ-032 Reset mid-transfer aborts it immediately; the owner receives no ack or err.

Structure
REQ-033 A shared package holds the state encoding (IDLE=0, OWN0=1, OWN1=2) and the 16-bit bus width constant.
REQ-034 One sub-module, arb_rr2 (two-way round-robin pick with last-owner register), is natural; all other logic is inline.

Verification
REQ-035 Both cyc rise together after reset -> OWN0 next cycle, s_adr_o=m0_adr_i; when m0 drops and PARK expires, OWN1 follows directly.
REQ-036 m0 runs 16 single beats with a 1-cycle cyc gap between beats, m1 requesting throughout, PARK=1 -> all 16 m0 acks occur before any s_cyc_o for m1.
REQ-037 Slave never acks, TIMEOUT=4 -> owner err_o=1 on the 4th stalled cycle, exactly one pulse, non-owner err_o=0.
REQ-038 s_ack_i=1 and s_err_i=1 together -> owner ack_o=1, err_o=0.
REQ-039 rst_n_i pulsed low mid-beat, asynchronous to clk_i -> s_cyc_o=0 immediately, state IDLE, no ack to the owner.
REQ-040 Alternating contention over 100 requests -> grant counts per master differ by at most 1.
